mem_stage_wb: RTL and testbench
===============================

// Module: mem_stage_wb
// PURPOSE
// - MEM stage directly downstream of the EX/MEM pipeline register; consumes its control/data fields.
// - Performs the data-memory access over a variable-latency req/ack port and stalls upstream while waiting.
// - Resolves the branch.
// - Selects the write-back value and registers it into MEM/WB outputs for the WB stage.
// PARAMETERS
// - DATA_W   32   data/address width
// - TIMEOUT  255  max WAIT cycles before abort (>=1)
// PORTS
// - clk             in   1       clock, rising edge
// - rst             in   1       asynchronous, active-high reset
// - zero_i          in   1       ALU zero flag from EX/MEM
// - pcsrc_i         in   1       branch instruction
// - regwrite_i      in   1       register write enable
// - memread_i       in   1       load
// - memwrite_i      in   1       store
// - memtoreg_i      in   2       00 ALU, 01 mem, 10 pc+4, 11 ALU
// - w_i             in   5       destination register
// - pcp4_i          in   DATA_W  pc+4
// - pc_i            in   DATA_W  branch target
// - o_i             in   DATA_W  ALU result / memory address
// - rdata2_i        in   DATA_W  store data
// - dmem_req        out  1       memory request
// - dmem_we         out  1       1 = write
// - dmem_addr       out  DATA_W  word address
// - dmem_wdata      out  DATA_W  store data
// - dmem_ack        in   1       access complete; rdata valid this cycle
// - dmem_rdata      in   DATA_W  load data
// - stall           out  1       freeze PC/IF/ID/EX/EX-MEM this cycle
// - br_taken        out  1       pcsrc_i & zero_i (combinational)
// - br_target       out  DATA_W  pc_i (combinational)
// - wb_regwrite     out  1       MEM/WB: write enable
// - wb_w            out  5       MEM/WB: destination
// - wb_data         out  DATA_W  MEM/WB: selected write-back value
// - bus_err         out  1       sticky: access timed out
// BEHAVIOUR
// - Reset: state=IDLE, timeout count=0, wb_*=0, bus_err=0.
// - Reset forces dmem_req=0 and stall=0 while rst=1, including mid-WAIT.
// - mem_op = memread_i | memwrite_i.
// - dmem_we = memwrite_i; dmem_addr = o_i; dmem_wdata = rdata2_i.
// - Upstream holds all inputs stable while stall=1.
// - FSM states: IDLE, WAIT.
// - IDLE, mem_op=0:
//   - req=0, stall=0.
//   - On clk: wb_regwrite<=regwrite_i, wb_w<=w_i, wb_data<=sel.
// - IDLE, mem_op=1:
//   - req=1 (combinational).
//   - If dmem_ack: zero-wait access, stall=0, MEM/WB loads as above; stay IDLE.
//   - Else: stall=1, MEM/WB loads bubble (wb_regwrite=0), go WAIT, count<=1.
// - WAIT:
//   - req=1, inputs stable.
//   - On ack: stall=0, MEM/WB loads the instruction, rdata taken from that cycle's dmem_rdata, go IDLE, count<=0.
//   - No ack, count<TIMEOUT: stall=1, bubble, count++.
//   - No ack, count==TIMEOUT: abort. req=0 and stall=0 that cycle. MEM/WB loads bubble (even for a load). bus_err<=1. Go IDLE.
// - sel: memtoreg 00/11 -> o_i; 01 -> dmem_rdata; 10 -> pcp4_i. Full DATA_W, no extension.
// - dmem_ack while req=0 is ignored.
// - Store: wb_regwrite follows regwrite_i (0 for a normal store).
// - bus_err clears only on rst.
// - Latency: one clock edge from inputs to wb_* when there is no wait.
// - Branch outputs ignore the FSM state.
// CONFIGURATION
// - Macro: MEM_MISALIGN_TRAP_EN.
// - Defined:
//   - mem_op with o_i[1:0]!=0 issues no request (req=0, stall=0).
//   - MEM/WB loads a bubble.
//   - Extra output misalign_err (1 bit, sticky, reset 0) is set.
// - Undefined:
//   - No misalign_err port.
//   - dmem_addr = {o_i[DATA_W-1:2],2'b00}; access proceeds normally.
// TESTING
// - ALU op, memtoreg=00, regwrite=1, w=5, o=0x1234 -> next edge: wb_regwrite=1, wb_w=5, wb_data=0x1234; stall=0.
// - Load o=0x40, ack same cycle, rdata=0xDEADBEEF -> stall never 1; wb_data=0xDEADBEEF.
// - Load with ack after 3 cycles, rdata=0xCAFE0001:
//   - stall=1 for 3 cycles; wb_regwrite=0 during them.
//   - Ack cycle: stall=0; next edge wb_data=0xCAFE0001.
// - TIMEOUT=4, store with no ack -> stall=1 for 4 cycles, then abort cycle (req=0); bus_err=1 thereafter; wb_regwrite=0.
// - pcsrc=1, zero=1, pc=0x100 -> br_taken=1, br_target=0x100. zero=0 -> br_taken=0.
// - rst asserted in WAIT -> req/stall drop immediately, all wb_*=0. After release, IDLE and a new load completes normally.

Source files
------------

// File: rtl/mem_stage_wb.sv
// mem_stage_wb: MEM pipeline stage with MEM/WB output register.
// Runs the data-memory access over a variable-latency req/ack port and
// holds the upstream pipeline while it waits. It also resolves the branch
// and selects and registers the write-back value.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// When the trap is enabled, a misaligned access issues no request,
// loads a bubble and sets the sticky misalign_err output.
//
// state | meaning
// IDLE  | no access outstanding; zero-wait accesses complete here
// WAIT  | request outstanding, pipeline stalled until ack or timeout
module mem_stage_wb #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zero_i,
  input  logic              pcsrc_i,
  input  logic              regwrite_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [1:0]        memtoreg_i,
  input  logic [4:0]        w_i,
  input  logic [DATA_W-1:0] pcp4_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] o_i,
  input  logic [DATA_W-1:0] rdata2_i,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              wb_regwrite,
  output logic [4:0]        wb_w,
  output logic [DATA_W-1:0] wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;

  logic              w_mem_op;
  logic              w_misalign;
  logic              w_go;
  logic              w_abort;
  logic [DATA_W-1:0] w_sel;

  assign w_mem_op = memread_i | memwrite_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op & (o_i[1:0] != 2'b00);
  assign dmem_addr  = o_i;
`else
  assign w_misalign = 1'b0;
  // Word port: byte offset bits are dropped, the access still proceeds.
  assign dmem_addr  = {o_i[DATA_W-1:2], 2'b00};
`endif

  assign w_go       = w_mem_op & ~w_misalign;
  assign w_abort    = (r_state == WAIT) & ~dmem_ack & (r_count == CNT_MAX);

  assign dmem_we    = memwrite_i;
  assign dmem_wdata = rdata2_i;

  // Request is held through WAIT except on the abort cycle; reset kills it at once.
  assign dmem_req   = ~rst & (((r_state == IDLE) & w_go) | ((r_state == WAIT) & ~w_abort));
  assign stall      = dmem_req & ~dmem_ack;

  assign br_taken   = pcsrc_i & zero_i;
  assign br_target  = pc_i;

  // Write-back source select; 11 aliases the ALU result.
  always_comb begin
    w_sel = o_i;
    case (memtoreg_i)
      2'b01:   w_sel = dmem_rdata;
      2'b10:   w_sel = pcp4_i;
      default: w_sel = o_i;
    endcase
  end

  // Access FSM, timeout counter, sticky error flags and MEM/WB register.
  // A bubble clears only wb_regwrite; wb_w/wb_data keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      wb_regwrite  <= 1'b0;
      wb_w         <= '0;
      wb_data      <= '0;
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_misalign) begin
            wb_regwrite  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_err <= 1'b1;
`endif
          end else if (w_go && !dmem_ack) begin
            wb_regwrite <= 1'b0;
            r_state     <= WAIT;
            r_count     <= CNT_W'(1);
          end else begin
            wb_regwrite <= regwrite_i;
            wb_w        <= w_i;
            wb_data     <= w_sel;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            wb_regwrite <= regwrite_i;
            wb_w        <= w_i;
            wb_data     <= w_sel;
            r_state     <= IDLE;
            r_count     <= '0;
          end else if (r_count == CNT_MAX) begin
            wb_regwrite <= 1'b0;
            bus_err     <= 1'b1;
            r_state     <= IDLE;
            r_count     <= '0;
          end else begin
            wb_regwrite <= 1'b0;
            r_count     <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed testbench for mem_stage_wb (TIMEOUT=4).
module tb_mem_stage_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        zero_i, pcsrc_i, regwrite_i, memread_i, memwrite_i;
  logic [1:0]  memtoreg_i;
  logic [4:0]  w_i;
  logic [31:0] pcp4_i, pc_i, o_i, rdata2_i;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, br_taken;
  logic [31:0] br_target;
  logic        wb_regwrite;
  logic [4:0]  wb_w;
  logic [31:0] wb_data;
  logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage_wb #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .zero_i(zero_i), .pcsrc_i(pcsrc_i),
    .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .memtoreg_i(memtoreg_i), .w_i(w_i), .pcp4_i(pcp4_i), .pc_i(pc_i),
    .o_i(o_i), .rdata2_i(rdata2_i), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .wb_regwrite(wb_regwrite), .wb_w(wb_w),
    .wb_data(wb_data),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    zero_i = 0; pcsrc_i = 0; regwrite_i = 0; memread_i = 0; memwrite_i = 0;
    memtoreg_i = 2'b00; w_i = 0; pcp4_i = 0; pc_i = 0; o_i = 0; rdata2_i = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    #12;
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL reset_wb_regwrite got %b exp 0", wb_regwrite); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    checks++; if (wb_w !== 5'd0) begin errors++; $display("FAIL reset_wb_w got %0d exp 0", wb_w); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_req_stall got %b/%b exp 0/0", dmem_req, stall); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_alu();
    regwrite_i = 1; memtoreg_i = 2'b00; w_i = 5; o_i = 32'h1234;
    #1;
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL alu_stall_req got %b/%b exp 0/0", stall, dmem_req); end
    step();
    checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("FAIL alu_wb_regwrite got %b exp 1", wb_regwrite); end
    checks++; if (wb_w !== 5'd5) begin errors++; $display("FAIL alu_wb_w got %0d exp 5", wb_w); end
    checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL alu_wb_data got %h exp 1234", wb_data); end
  endtask

  task automatic test_sel();
    memtoreg_i = 2'b10; pcp4_i = 32'h0000_0204; o_i = 32'h0000_0055; w_i = 9;
    step();
    checks++; if (wb_data !== 32'h0000_0204) begin errors++; $display("FAIL sel10_wb_data got %h exp 00000204", wb_data); end
    memtoreg_i = 2'b11; dmem_rdata = 32'hFFFF_0000;
    step();
    checks++; if (wb_data !== 32'h0000_0055) begin errors++; $display("FAIL sel11_wb_data got %h exp 00000055", wb_data); end
    checks++; if (wb_w !== 5'd9) begin errors++; $display("FAIL sel11_wb_w got %0d exp 9", wb_w); end
    clear_inputs();
  endtask

  task automatic test_load_zero_wait();
    memread_i = 1; memtoreg_i = 2'b01; regwrite_i = 1; w_i = 7; o_i = 32'h40;
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (dmem_req !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL zw_req_stall got %b/%b exp 1/0", dmem_req, stall); end
    checks++; if (dmem_addr !== 32'h40 || dmem_we !== 1'b0) begin errors++; $display("FAIL zw_addr_we got %h/%b exp 00000040/0", dmem_addr, dmem_we); end
    step();
    checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_wb_data got %h exp deadbeef", wb_data); end
    checks++; if (wb_regwrite !== 1'b1 || wb_w !== 5'd7) begin errors++; $display("FAIL zw_wb_ctl got %b/%0d exp 1/7", wb_regwrite, wb_w); end
    clear_inputs();
  endtask

  task automatic test_store();
    memwrite_i = 1; regwrite_i = 0; o_i = 32'h80; rdata2_i = 32'h0000_0099; dmem_ack = 1;
    #1;
    checks++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'h99) begin errors++; $display("FAIL st_we_wdata got %b/%h exp 1/00000099", dmem_we, dmem_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st_stall got %b exp 0", stall); end
    step();
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL st_wb_regwrite got %b exp 0", wb_regwrite); end
    clear_inputs();
  endtask

  task automatic test_load_wait();
    memread_i = 1; memtoreg_i = 2'b01; regwrite_i = 1; w_i = 12; o_i = 32'h84;
    dmem_ack = 0; dmem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL lw_stall_%0d got %b/%b exp 1/1", i, stall, dmem_req); end
      step();
      checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL lw_bubble_%0d got %b exp 0", i, wb_regwrite); end
    end
    dmem_ack = 1; dmem_rdata = 32'hCAFE_0001;
    #1;
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b1) begin errors++; $display("FAIL lw_ack_stall_req got %b/%b exp 0/1", stall, dmem_req); end
    step();
    checks++; if (wb_data !== 32'hCAFE_0001) begin errors++; $display("FAIL lw_wb_data got %h exp cafe0001", wb_data); end
    checks++; if (wb_regwrite !== 1'b1 || wb_w !== 5'd12) begin errors++; $display("FAIL lw_wb_ctl got %b/%0d exp 1/12", wb_regwrite, wb_w); end
    clear_inputs();
    #1;
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL lw_back_idle got %b/%b exp 0/0", stall, dmem_req); end
  endtask

  task automatic test_timeout();
    memwrite_i = 1; regwrite_i = 1; o_i = 32'h10; rdata2_i = 32'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL to_stall_%0d got %b/%b exp 1/1", i, stall, dmem_req); end
      step();
    end
    #1;
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL to_abort_cycle got %b/%b exp 0/0", stall, dmem_req); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_bus_err_early got %b exp 0", bus_err); end
    step();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err got %b exp 1", bus_err); end
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL to_wb_regwrite got %b exp 0", wb_regwrite); end
    // Ack with no request pending must be ignored; ALU op proceeds normally.
    clear_inputs();
    dmem_ack = 1; regwrite_i = 1; w_i = 3; o_i = 32'h0000_0ABC;
    step();
    dmem_ack = 0;
    #1;
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err_sticky got %b exp 1", bus_err); end
    checks++; if (wb_data !== 32'h0ABC || wb_regwrite !== 1'b1) begin errors++; $display("FAIL to_stray_ack got %h/%b exp 00000abc/1", wb_data, wb_regwrite); end
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL to_stray_ack_idle got %b/%b exp 0/0", stall, dmem_req); end
  endtask

  task automatic test_branch();
    pcsrc_i = 1; zero_i = 1; pc_i = 32'h100;
    #1;
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h100) begin errors++; $display("FAIL br_taken got %b/%h exp 1/00000100", br_taken, br_target); end
    zero_i = 0;
    #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b exp 0", br_taken); end
    pcsrc_i = 0; zero_i = 1;
    #1;
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_no_branch got %b exp 0", br_taken); end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    regwrite_i = 1; w_i = 21; o_i = 32'h0000_0ABC;
    step();
    memread_i = 1; memtoreg_i = 2'b01; o_i = 32'h200; dmem_ack = 0;
    step();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_in_wait got %b exp 1", stall); end
    rst = 1;
    #1;
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rw_rst_req_stall got %b/%b exp 0/0", stall, dmem_req); end
    checks++; if (wb_data !== 32'h0 || wb_w !== 5'd0 || wb_regwrite !== 1'b0) begin errors++; $display("FAIL rw_rst_wb got %h/%0d/%b exp 0/0/0", wb_data, wb_w, wb_regwrite); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rw_rst_bus_err got %b exp 0", bus_err); end
    step();
    step();
    rst = 0;
    #1;
    checks++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL rw_new_req got %b/%b exp 1/1", stall, dmem_req); end
    dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_ack_stall got %b exp 0", stall); end
    step();
    checks++; if (wb_data !== 32'h1111_2222 || wb_regwrite !== 1'b1) begin errors++; $display("FAIL rw_new_load got %h/%b exp 11112222/1", wb_data, wb_regwrite); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    memread_i = 1; memtoreg_i = 2'b01; regwrite_i = 1; w_i = 4; o_i = 32'h42;
    dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL ma_req_stall got %b/%b exp 0/0", dmem_req, stall); end
    step();
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL ma_bubble got %b exp 0", wb_regwrite); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL ma_err got %b exp 1", misalign_err); end
`else
    #1;
    checks++; if (dmem_addr !== 32'h40 || dmem_req !== 1'b1) begin errors++; $display("FAIL ma_addr_req got %h/%b exp 00000040/1", dmem_addr, dmem_req); end
    step();
    checks++; if (wb_data !== 32'h5555_AAAA || wb_regwrite !== 1'b1) begin errors++; $display("FAIL ma_load got %h/%b exp 5555aaaa/1", wb_data, wb_regwrite); end
`endif
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_sel();
    test_load_zero_wait();
    test_store();
    test_load_wait();
    test_timeout();
    test_branch();
    test_reset_in_wait();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
